// File: rtl/tm1638_pkg.sv
// Shared constants, state encodings and byte-builder helpers for the TM1638 refresh sequencer.
package tm1638_pkg;

   localparam logic [7:0] CMD_DATA_WR  = 8'h40;  // write data, auto-increment address
   localparam logic [7:0] CMD_ADDR0    = 8'hC0;  // set address 0
   localparam logic [7:0] CMD_DISP_OFF = 8'h80;
   localparam logic [7:0] CMD_DISP_ON  = 8'h88;

   localparam int unsigned NUM_ADDR = 16;

   typedef enum logic [2:0] {
      StIdle,
      StF1Cmd,
      StF2Addr,
      StF2Data,
      StF3Ctrl,
      StFin
   } tm1638_state_e;

   // Position inside one stb-framed transfer.
   typedef enum logic [1:0] {
      PhLead,
      PhBytes,
      PhTrail,
      PhGap
   } tm1638_phase_e;

   // Even addresses carry digit segments, odd addresses carry one discrete LED in bit 0.
   function automatic logic [7:0] ram_byte(input logic [63:0] seg, input logic [7:0] led,
                                           input logic [3:0] addr);
      logic [7:0] b;
      if (addr[0]) b = {7'b0, led[addr[3:1]]};
      else         b = seg[{addr[3:1], 3'b000} +: 8];
      return b;
   endfunction

   function automatic logic [7:0] ctrl_byte(input logic on, input logic [2:0] bri);
      return (on ? CMD_DISP_ON : CMD_DISP_OFF) | {5'b0, bri};
   endfunction

endpackage

// File: rtl/tm1638_refresh_sequencer_if.sv
// Request/status handshake plus the serial pin bundle of the refresh sequencer.
interface tm1638_refresh_sequencer_if;

   logic        refresh_req;
   logic [63:0] seg_data;
   logic [7:0]  led;
   logic [2:0]  brightness;
   logic        display_on;
   logic        busy;
   logic        done;
   logic        dio;
   logic        sclk;
   logic        stb;
   logic [7:0]  data_check;

   // Master is the display-content producer, slave is the sequencer.
   modport master (
      output refresh_req, seg_data, led, brightness, display_on,
      input  busy, done, dio, sclk, stb, data_check
   );

   modport slave (
      input  refresh_req, seg_data, led, brightness, display_on,
      output busy, done, dio, sclk, stb, data_check
   );

endinterface

// File: rtl/tm1638_byte_tx.sv
// Shifts one byte LSB first: sclk low N cycles then high N cycles per bit, dio changes on the fall.
module tm1638_byte_tx #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_byte_in,
   output logic       o_ready,
   output logic       o_sclk,
   output logic       o_dio,
   output logic [7:0] o_data_check
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic             r_active;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_byte;
   logic             r_sclk;
   logic             r_dio;
   logic [7:0]       r_data_check;

   logic             w_phase_end;
   logic [2:0]       w_bit_nxt;

   assign w_phase_end = (r_cnt == CNT_MAX);
   assign w_bit_nxt   = r_bit + 3'd1;

   // Ready also in the last cycle of a byte so a following load keeps bits back to back.
   assign o_ready = !r_active || (r_sclk && w_phase_end && (r_bit == 3'd7));

   // Bit divider, bit counter and pin registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_active     <= 1'b0;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_byte       <= '0;
         r_sclk       <= 1'b1;
         r_dio        <= 1'b1;
         r_data_check <= '0;
      end else if (i_load && o_ready) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_byte   <= i_byte_in;
         r_sclk   <= 1'b0;
         r_dio    <= i_byte_in[0];
      end else if (r_active) begin
         if (w_phase_end) begin
            r_cnt <= '0;
            if (!r_sclk) begin
               r_sclk <= 1'b1;
               if (r_bit == 3'd7) r_data_check <= r_byte;
            end else if (r_bit == 3'd7) begin
               r_active <= 1'b0;
               r_dio    <= 1'b1;
            end else begin
               r_bit  <= w_bit_nxt;
               r_sclk <= 1'b0;
               r_dio  <= r_byte[w_bit_nxt];
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_sclk       = r_sclk;
   assign o_dio        = r_dio;
   assign o_data_check = r_data_check;

endmodule

// File: rtl/tm1638_refresh_sequencer.sv
// Snapshots display content on request and sends the data-command, RAM-burst and control frames.
module tm1638_refresh_sequencer
   import tm1638_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25
) (
   input logic                          Clk_50M,
   input logic                          RST,
   tm1638_refresh_sequencer_if.slave    bus
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [4:0] RAM_FRAME_BYTES = 5'(NUM_ADDR + 1);

   tm1638_state_e    r_state;
   tm1638_phase_e    r_phase;
   logic [CNT_W-1:0] r_cnt;
   logic [4:0]       r_idx;   // bytes already loaded in the current frame
   logic             r_stb;
   logic             r_busy;
   logic             r_done;
   logic             r_pend;
   logic [63:0]      r_seg;
   logic [7:0]       r_led;
   logic [2:0]       r_bri;
   logic             r_on;

   logic             w_cnt_end;
   logic             w_in_frame;
   logic [4:0]       w_frame_bytes;
   logic [3:0]       w_addr;
   logic [7:0]       w_tx_byte;
   logic             w_load;
   logic             w_tx_ready;
   logic             w_sclk;
   logic             w_dio;
   logic [7:0]       w_data_check;

   assign w_cnt_end = (r_cnt == CNT_MAX);
   assign w_addr    = r_idx[3:0] - 4'd1;  // byte 0 of the RAM frame is the address command

   // Byte selection and load strobe for the byte shifter.
   always_comb begin
      w_in_frame    = (r_state == StF1Cmd) || (r_state == StF2Addr) ||
                      (r_state == StF2Data) || (r_state == StF3Ctrl);
      w_frame_bytes = ((r_state == StF2Addr) || (r_state == StF2Data)) ? RAM_FRAME_BYTES : 5'd1;
      w_tx_byte     = 8'hFF;
      case (r_state)
         StF1Cmd:  w_tx_byte = CMD_DATA_WR;
         StF2Addr: w_tx_byte = (r_idx == 5'd0) ? CMD_ADDR0 : ram_byte(r_seg, r_led, w_addr);
         StF2Data: w_tx_byte = ram_byte(r_seg, r_led, w_addr);
         StF3Ctrl: w_tx_byte = ctrl_byte(r_on, r_bri);
         default:  w_tx_byte = 8'hFF;
      endcase
      w_load = w_in_frame &&
               (((r_phase == PhLead) && w_cnt_end) ||
                ((r_phase == PhBytes) && w_tx_ready && (r_idx < w_frame_bytes)));
   end

   tm1638_byte_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_byte_tx (
      .i_clk        (Clk_50M),
      .i_rst        (RST),
      .i_load       (w_load),
      .i_byte_in    (w_tx_byte),
      .o_ready      (w_tx_ready),
      .o_sclk       (w_sclk),
      .o_dio        (w_dio),
      .o_data_check (w_data_check)
   );

   // Frame FSM: lead/bytes/trail/gap timing, shadow capture, pending request and done pulse.
   always_ff @(posedge Clk_50M) begin
      if (RST) begin
         r_state <= StIdle;
         r_phase <= PhLead;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_stb   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pend  <= 1'b0;
         r_seg   <= '0;
         r_led   <= '0;
         r_bri   <= '0;
         r_on    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.refresh_req) begin
                  r_seg   <= bus.seg_data;
                  r_led   <= bus.led;
                  r_bri   <= bus.brightness;
                  r_on    <= bus.display_on;
                  r_busy  <= 1'b1;
                  r_stb   <= 1'b0;
                  r_state <= StF1Cmd;
                  r_phase <= PhLead;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end
            end
            StFin: begin
               // A request landing on the done cycle counts as pending: restart with no idle gap.
               if (r_pend || bus.refresh_req) begin
                  r_seg   <= bus.seg_data;
                  r_led   <= bus.led;
                  r_bri   <= bus.brightness;
                  r_on    <= bus.display_on;
                  r_pend  <= 1'b0;
                  r_stb   <= 1'b0;
                  r_state <= StF1Cmd;
                  r_phase <= PhLead;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: begin
               if (bus.refresh_req) r_pend <= 1'b1;
               case (r_phase)
                  PhLead: begin
                     if (w_cnt_end) begin
                        r_cnt   <= '0;
                        r_phase <= PhBytes;
                        r_idx   <= 5'd1;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  PhBytes: begin
                     if (w_load) begin
                        r_idx <= r_idx + 5'd1;
                        if (r_state == StF2Addr) r_state <= StF2Data;
                     end else if (w_tx_ready) begin
                        r_phase <= PhTrail;
                        r_cnt   <= '0;
                     end
                  end
                  PhTrail: begin
                     if (w_cnt_end) begin
                        r_cnt   <= '0;
                        r_stb   <= 1'b1;
                        r_phase <= PhGap;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  PhGap: begin
                     if (w_cnt_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_phase <= PhLead;
                        case (r_state)
                           StF1Cmd: begin
                              r_state <= StF2Addr;
                              r_stb   <= 1'b0;
                           end
                           StF2Data: begin
                              r_state <= StF3Ctrl;
                              r_stb   <= 1'b0;
                           end
                           StF3Ctrl: begin
                              r_state <= StFin;
                              r_done  <= 1'b1;
                           end
                           default: r_state <= StIdle;
                        endcase
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  default: r_phase <= PhLead;
               endcase
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.stb        = r_stb;
   assign bus.sclk       = w_sclk;
   assign bus.dio        = w_dio;
   assign bus.data_check = w_data_check;

endmodule

// File: tb/tb_tm1638_refresh_sequencer.sv
// Directed bench: decodes the serial link and checks frames, timing, pending and reset behaviour.
module tb_tm1638_refresh_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic rst2;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   tm1638_refresh_sequencer_if bus1 ();
   tm1638_refresh_sequencer_if bus2 ();

   tm1638_refresh_sequencer #(
      .CLK_DIV (2)
   ) dut (
      .Clk_50M (clk),
      .RST     (rst),
      .bus     (bus1)
   );

   tm1638_refresh_sequencer #(
      .CLK_DIV (25)
   ) dut_slow (
      .Clk_50M (clk),
      .RST     (rst2),
      .bus     (bus2)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Link decoder and event recorders, sampled on the falling clock edge.
   logic [7:0] got_q[$];
   int         flen_q[$];
   int         done_q[$];
   int         stbf_q[$];
   int         rise2_q[$];
   int         done2_q[$];
   int         busy_falls = 0;

   initial begin
      logic [7:0] sh;
      int         nbits;
      int         flen;
      logic       p_sclk, p_stb, p_busy, p_sclk2;
      sh = '0; nbits = 0; flen = 0;
      p_sclk = 1'b1; p_stb = 1'b1; p_busy = 1'b0; p_sclk2 = 1'b1;
      forever begin
         @(negedge clk);
         if (p_stb && !bus1.stb) begin
            nbits = 0;
            flen  = 0;
            stbf_q.push_back(cyc);
         end
         if (!p_sclk && bus1.sclk && !bus1.stb) begin
            sh = {bus1.dio, sh[7:1]};
            nbits++;
            if (nbits == 8) begin
               got_q.push_back(sh);
               nbits = 0;
               flen++;
            end
         end
         if (!p_stb && bus1.stb) flen_q.push_back(flen);
         if (bus1.done) done_q.push_back(cyc);
         if (p_busy && !bus1.busy) busy_falls++;
         if (!p_sclk2 && bus2.sclk) rise2_q.push_back(cyc);
         if (bus2.done) done2_q.push_back(cyc);
         p_sclk  = bus1.sclk;
         p_stb   = bus1.stb;
         p_busy  = bus1.busy;
         p_sclk2 = bus2.sclk;
      end
   end

   logic [7:0] exp_tab [3][19];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Step to just after the falling edge so the recorders have already run.
   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) nstep();
   endtask

   task automatic pulse_req1(output int acc);
      bus1.refresh_req = 1'b1;
      acc = cyc;
      nstep();
      bus1.refresh_req = 1'b0;
   endtask

   task automatic wait_done(input int n, input int limit);
      int k;
      k = 0;
      while ((done_q.size() < n) && (k < limit)) begin
         nstep();
         k++;
      end
      check_eq("done_seen", 64'(done_q.size() >= n), 64'd1);
   endtask

   task automatic check_seq(input int which, input int bb, input int fb, input string tag);
      for (int i = 0; i < 19; i++)
         check_eq($sformatf("%s_byte%0d", tag, i), got_q[bb + i], exp_tab[which][i]);
      check_eq({tag, "_flen0"}, flen_q[fb], 1);
      check_eq({tag, "_flen1"}, flen_q[fb + 1], 17);
      check_eq({tag, "_flen2"}, flen_q[fb + 2], 1);
   endtask

   task automatic set_in1(input logic [63:0] seg, input logic [7:0] led, input logic [2:0] bri,
                          input logic on);
      bus1.seg_data   = seg;
      bus1.led        = led;
      bus1.brightness = bri;
      bus1.display_on = on;
   endtask

   localparam logic [63:0] SEG_A = 64'h7F06_5B4F_6607_6D3F;

   initial begin
      int acc, dummy, bb, bf, bd, bs, bfall;
      exp_tab[0] = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h6D, 8'h00, 8'h07, 8'h00, 8'h66, 8'h00,
                     8'h4F, 8'h00, 8'h5B, 8'h00, 8'h06, 8'h00, 8'h7F, 8'h01, 8'h8F};
      exp_tab[1] = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h6D, 8'h00, 8'h07, 8'h00, 8'h66, 8'h00,
                     8'h4F, 8'h00, 8'h5B, 8'h00, 8'h06, 8'h00, 8'h7F, 8'h01, 8'h83};
      exp_tab[2] = '{8'h40, 8'hC0, 8'h3F, 8'h00, 8'h6D, 8'h00, 8'h07, 8'h00, 8'h66, 8'h00,
                     8'h4F, 8'h00, 8'h5B, 8'h00, 8'h06, 8'h00, 8'h7F, 8'h00, 8'h8D};
      rst  = 1'b1;
      rst2 = 1'b1;
      bus1.refresh_req = 1'b0;
      bus2.refresh_req = 1'b0;
      set_in1(64'd0, 8'd0, 3'd0, 1'b0);
      bus2.seg_data   = SEG_A;
      bus2.led        = 8'h81;
      bus2.brightness = 3'd7;
      bus2.display_on = 1'b1;

      // Reset for three cycles, then idle.
      repeat (3) nstep();
      rst  = 1'b0;
      rst2 = 1'b0;
      nstep();
      check_eq("rst_stb", bus1.stb, 1);
      check_eq("rst_sclk", bus1.sclk, 1);
      check_eq("rst_dio", bus1.dio, 1);
      check_eq("rst_busy", bus1.busy, 0);
      check_eq("rst_done", bus1.done, 0);
      check_eq("rst_data_check", bus1.data_check, 8'h00);
      repeat (1000) nstep();
      check_eq("idle_stb_falls", stbf_q.size(), 0);
      check_eq("idle_bytes", got_q.size(), 0);
      check_eq("idle_busy", bus1.busy, 0);
      check_eq("idle_sclk", bus1.sclk, 1);

      // Basic sequence.
      bb = got_q.size(); bf = flen_q.size(); bd = done_q.size(); bs = stbf_q.size();
      set_in1(SEG_A, 8'h81, 3'd7, 1'b1);
      pulse_req1(acc);
      check_eq("basic_busy", bus1.busy, 1);
      wait_done(bd + 1, 2000);
      check_seq(0, bb, bf, "basic");
      check_eq("basic_stb_fall_cyc", stbf_q[bs] - acc, 1);
      check_eq("basic_done_cyc", done_q[bd] - acc, 627);
      check_eq("basic_data_check", bus1.data_check, 8'h8F);
      nstep();
      check_eq("basic_busy_after", bus1.busy, 0);
      check_eq("basic_done_width", bus1.done, 0);

      // Display off, inputs disturbed mid-sequence.
      repeat (3) nstep();
      bb = got_q.size(); bf = flen_q.size(); bd = done_q.size();
      set_in1(SEG_A, 8'h81, 3'd3, 1'b0);
      pulse_req1(acc);
      wait_cyc(acc + 50);
      set_in1(64'h0123_4567_89AB_CDEF, 8'h5A, 3'd6, 1'b1);
      wait_done(bd + 1, 2000);
      check_seq(1, bb, bf, "off");
      check_eq("off_data_check", bus1.data_check, 8'h83);

      // Pending request at cycle 100, dropped one at 200, new inputs before the restart.
      repeat (3) nstep();
      bb = got_q.size(); bf = flen_q.size(); bd = done_q.size(); bs = stbf_q.size();
      bfall = busy_falls;
      set_in1(SEG_A, 8'h81, 3'd7, 1'b1);
      pulse_req1(acc);
      wait_cyc(acc + 100);
      pulse_req1(dummy);
      wait_cyc(acc + 200);
      pulse_req1(dummy);
      wait_cyc(acc + 300);
      set_in1(SEG_A, 8'h00, 3'd5, 1'b1);
      wait_done(bd + 2, 2000);
      check_eq("pend_done1_cyc", done_q[bd] - acc, 627);
      check_eq("pend_done2_cyc", done_q[bd + 1] - acc, 1254);
      check_eq("pend_busy_held", busy_falls - bfall, 0);
      repeat (700) nstep();
      check_eq("pend_done_count", done_q.size() - bd, 2);
      check_eq("pend_busy_falls", busy_falls - bfall, 1);
      check_eq("pend_stb_falls", stbf_q.size() - bs, 6);
      check_seq(0, bb, bf, "pendA");
      check_seq(2, bb + 19, bf + 3, "pendB");

      // Reset in the middle of the RAM burst, then a clean sequence.
      set_in1(SEG_A, 8'h81, 3'd7, 1'b1);
      pulse_req1(acc);
      wait_cyc(acc + 150);
      check_eq("mid_stb_low", bus1.stb, 0);
      rst = 1'b1;
      nstep();
      check_eq("mid_rst_stb", bus1.stb, 1);
      check_eq("mid_rst_sclk", bus1.sclk, 1);
      check_eq("mid_rst_dio", bus1.dio, 1);
      check_eq("mid_rst_busy", bus1.busy, 0);
      check_eq("mid_rst_data_check", bus1.data_check, 8'h00);
      rst = 1'b0;
      repeat (2) nstep();
      bb = got_q.size(); bf = flen_q.size(); bd = done_q.size();
      pulse_req1(acc);
      wait_done(bd + 1, 2000);
      check_seq(0, bb, bf, "post_rst");
      check_eq("post_rst_done_cyc", done_q[bd] - acc, 627);

      // Default divider instance.
      bus2.refresh_req = 1'b1;
      acc = cyc;
      nstep();
      bus2.refresh_req = 1'b0;
      for (int k = 0; (k < 9000) && (done2_q.size() == 0); k++) nstep();
      check_eq("slow_done_seen", done2_q.size(), 1);
      check_eq("slow_sclk_period", rise2_q[1] - rise2_q[0], 50);
      check_eq("slow_done_cyc", done2_q[0] - acc, 7826);
      check_eq("slow_data_check", bus2.data_check, 8'h8F);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
